mul_seq: RTL and testbench
==========================

# mul_seq

Iterative multiply sequencer for the multi-cycle CPU's MULT/MULTU instructions. It accepts a request from the main control FSM and runs a one-bit-per-cycle shift-add datapath over WIDTH cycles. It applies sign correction for signed operations and owns the architectural HI/LO registers. It provides the busy/done handshake the control FSM uses to stall MFHI/MFLO, and it handles MTHI/MTLO writes.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- op_signed  in  1  0 = MULTU, 1 = MULT (two's complement); sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- wr_hi  in  1  MTHI write enable.
- wr_lo  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  high while a multiply is in flight (state != IDLE).
- done  out  1  one-cycle pulse; HI/LO hold the new product this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on start.
  - Latch |a| and |b| (magnitudes when op_signed = 1, raw values otherwise).
  - Latch neg = op_signed & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and set cnt = 0.
- RUN, once per cycle:
  - If mplier[0] = 1, add mcand to acc.
  - Shift mcand left 1 and mplier right 1; cnt++.
  - After the cycle with cnt = WIDTH-1, go to FIX.
- FIX: write hi:lo = neg ? -acc : acc (2*WIDTH-bit two's complement), set done, go to IDLE.
- Arithmetic rules:
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned; no overflow case exists.
  - The accumulator never overflows 2*WIDTH bits.
- start while busy is ignored (not queued). The control FSM must not issue it.
- wr_hi / wr_lo are honored only in IDLE and dropped while busy.
  - If asserted in the same cycle as an accepted start, the write takes effect. The product overwrites it at FIX.
  - wr_hi and wr_lo asserted together write both registers with wdata.
- hi/lo are unchanged during RUN; the old values stay readable.
- Reset (any state, including mid-RUN): state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, acc/cnt cleared. An in-flight product is discarded.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0.
- Edge E0 accepts start; busy = 1 from E0 to E33 (33 cycles).
- E1..E32 are the RUN iterations.
- E33 is the FIX edge: hi/lo updated, done = 1 for exactly one cycle, busy = 0.
- Start-to-result latency is 33 cycles, fixed and independent of operand values.
- A new start is accepted in the done cycle (back-to-back). That start's done arrives 33 cycles later.
- done is never asserted without a preceding accepted start since the last reset.

## Structure
- Shared package mul_pkg holds:
  - state enum {IDLE, RUN, FIX};
  - WIDTH default constant;
  - the op_signed encoding constants (OP_MULTU = 0, OP_MULT = 1).
- Sub-module mul_step: combinational single iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, mcand<<1, mplier>>1.
- mul_seq keeps the FSM, cnt ($clog2(WIDTH) bits), sign latch, and HI/LO.

## Test plan
- MULTU, a = 7, b = 6 → done at start+33, hi = 0x00000000, lo = 0x0000002A, busy high for exactly 33 cycles.
- MULTU, a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. Same operands with MULT → hi = 0, lo = 1.
- MULT, a = 0xFFFFFFFE (−2), b = 3 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. MULT, a = b = 0x80000000 → hi = 0x40000000, lo = 0.
- Back-to-back: second start (MULTU 3×5) in the first op's done cycle → first done with its product, second done 33 cycles later with lo = 15. A start at mid-RUN cycle 10 is ignored, with no extra done.
- MTHI 0xDEADBEEF in IDLE → hi updates next edge. wr_lo during RUN → lo unchanged. wr_lo in the same cycle as start → lo = wdata until FIX, then the product.
- Reset asserted at RUN cycle 16 → next cycle busy = 0, done = 0, hi = lo = 0. No done follows, and a fresh start completes normally.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiply sequencer.
package mul_pkg;

  // Default operand width; the product is twice this width.
  localparam int unsigned MUL_WIDTH = 32;

  // op_signed encoding.
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_MULT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage : mul_pkg

// File: rtl/mul_seq_if.sv
// Request/result bundle between the CPU control FSM (master) and mul_seq (slave).
//   start, op_signed, a, b     : multiply request, sampled while idle
//   wr_hi, wr_lo, wdata        : MTHI/MTLO writes, honored only while idle
//   busy, done, hi, lo         : sequencer status and architectural HI/LO
interface mul_seq_if #(
  parameter int unsigned WIDTH = mul_pkg::MUL_WIDTH
);
  logic             start;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_signed, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_signed, a, b, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface : mul_seq_if

// File: rtl/mul_step.sv
// One combinational shift-add iteration of the multiplier.
//   acc, mcand (2*WIDTH) and mplier (WIDTH) in; next-iteration values out.
module mul_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);

  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end

endmodule : mul_step

// File: rtl/mul_seq.sv
// Iterative MULT/MULTU sequencer owning HI/LO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mul_seq_if slave (request, MTHI/MTLO writes, busy/done, hi/lo)
// Magnitudes are multiplied unsigned over WIDTH cycles, then the sign is
// applied to the full product in a single FIX cycle.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  mul_seq_if.slave   bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [PW-1:0]    acc_nxt;
  logic [PW-1:0]    mcand_nxt;
  logic [WIDTH-1:0] mplier_nxt;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             neg_c;
  logic [PW-1:0]    prod_c;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

  // Operand magnitudes; negating the most negative value yields itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    a_mag_c = bus.a;
    b_mag_c = bus.b;
    if (bus.op_signed == OP_MULT && bus.a[WIDTH-1]) a_mag_c = -bus.a;
    if (bus.op_signed == OP_MULT && bus.b[WIDTH-1]) b_mag_c = -bus.b;
    neg_c  = (bus.op_signed == OP_MULT) & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    prod_c = neg ? -acc : acc;
  end

  // Sequencer FSM, datapath registers and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land even alongside an accepted start; FIX overwrites later.
          if (bus.wr_hi) hi_q <= bus.wdata;
          if (bus.wr_lo) lo_q <= bus.wdata;
          if (bus.start) begin
            mcand  <= PW'(a_mag_c);
            mplier <= b_mag_c;
            neg    <= neg_c;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          hi_q   <= prod_c[PW-1:WIDTH];
          lo_q   <= prod_c[WIDTH-1:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
module tb_mul_seq;
  import mul_pkg::*;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   n;
  int   bsy;
  int   extra;

  mul_seq_if #(.WIDTH(W)) bus_if ();

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for one edge; caller is aligned #1 after a posedge.
  task automatic start_op(input logic sgn, input logic [W-1:0] ma, input logic [W-1:0] mb);
    bus_if.start     = 1'b1;
    bus_if.op_signed = sgn;
    bus_if.a         = ma;
    bus_if.b         = mb;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.wr_hi = 1'b0;
    bus_if.wr_lo = 1'b0;
  endtask

  // Advance until done is seen; cnt is edges since the accepting edge.
  task automatic wait_done(input int n0, output int cnt);
    cnt = n0;
    while (cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (bus_if.done) break;
    end
  endtask

  task automatic run_mul(input string tag, input logic sgn, input logic [W-1:0] ma,
                         input logic [W-1:0] mb, input logic [W-1:0] eh, input logic [W-1:0] el);
    int c;
    start_op(sgn, ma, mb);
    wait_done(0, c);
    chk({tag, "_lat"}, 64'(c), 64'd33);
    chk({tag, "_hi"}, 64'(bus_if.hi), 64'(eh));
    chk({tag, "_lo"}, 64'(bus_if.lo), 64'(el));
    chk({tag, "_busy_at_done"}, 64'(bus_if.busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(bus_if.done), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_if.start = 1'b0; bus_if.op_signed = OP_MULTU;
    bus_if.a = '0; bus_if.b = '0;
    bus_if.wr_hi = 1'b0; bus_if.wr_lo = 1'b0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_done", 64'(bus_if.done), 64'd0);
    chk("rst_hi", 64'(bus_if.hi), 64'd0);
    chk("rst_lo", 64'(bus_if.lo), 64'd0);

    // MULTU 7*6 with busy-width measurement
    start_op(OP_MULTU, 32'd7, 32'd6);
    bsy = bus_if.busy ? 1 : 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.done) break;
      if (bus_if.busy) bsy++;
    end
    chk("m7x6_lat", 64'(n), 64'd33);
    chk("m7x6_busy_cycles", 64'(bsy), 64'd33);
    chk("m7x6_hi", 64'(bus_if.hi), 64'h0);
    chk("m7x6_lo", 64'(bus_if.lo), 64'h2A);
    @(posedge clk); #1;
    chk("m7x6_done_pulse", 64'(bus_if.done), 64'd0);

    run_mul("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_mul("mult_ff",  OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_mul("mult_m2x3", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_mul("mult_min2", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_mul("mult_maxxm1", OP_MULT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001);

    // Back-to-back: second start issued in the first op's done cycle
    start_op(OP_MULTU, 32'd100, 32'd200);
    wait_done(0, n);
    chk("b2b1_lat", 64'(n), 64'd33);
    chk("b2b1_lo", 64'(bus_if.lo), 64'h4E20);
    start_op(OP_MULTU, 32'd3, 32'd5);
    chk("b2b2_busy", 64'(bus_if.busy), 64'd1);
    chk("b2b2_done_clr", 64'(bus_if.done), 64'd0);
    wait_done(0, n);
    chk("b2b2_lat", 64'(n), 64'd33);
    chk("b2b2_hi", 64'(bus_if.hi), 64'h0);
    chk("b2b2_lo", 64'(bus_if.lo), 64'd15);

    // Start mid-RUN is ignored
    @(posedge clk); #1;
    start_op(OP_MULTU, 32'd9, 32'd9);
    n = 0;
    repeat (10) begin @(posedge clk); #1; n++; end
    bus_if.start = 1'b1; bus_if.a = 32'd1000; bus_if.b = 32'd1000;
    @(posedge clk); #1; n++;
    bus_if.start = 1'b0;
    wait_done(n, n);
    chk("ign_lat", 64'(n), 64'd33);
    chk("ign_lo", 64'(bus_if.lo), 64'd81);
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (bus_if.done) extra++; end
    chk("ign_no_extra_done", 64'(extra), 64'd0);

    // MTHI in IDLE
    bus_if.wr_hi = 1'b1; bus_if.wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus_if.wr_hi = 1'b0;
    chk("mthi", 64'(bus_if.hi), 64'hDEADBEEF);

    // MTLO with start: visible until FIX, then product
    bus_if.wr_lo = 1'b1; bus_if.wdata = 32'hCAFEF00D;
    start_op(OP_MULTU, 32'd7, 32'd6);
    chk("mtlo_start_lo", 64'(bus_if.lo), 64'hCAFEF00D);
    chk("mtlo_start_hi_kept", 64'(bus_if.hi), 64'hDEADBEEF);
    wait_done(0, n);
    chk("mtlo_start_lat", 64'(n), 64'd33);
    chk("mtlo_start_prod", 64'(bus_if.lo), 64'h2A);

    // MTLO during RUN is dropped
    start_op(OP_MULTU, 32'd11, 32'd13);
    n = 0;
    repeat (4) begin @(posedge clk); #1; n++; end
    bus_if.wr_lo = 1'b1; bus_if.wdata = 32'h12345678;
    @(posedge clk); #1; n++;
    bus_if.wr_lo = 1'b0;
    chk("mtlo_run_drop", 64'(bus_if.lo), 64'h2A);
    wait_done(n, n);
    chk("mtlo_run_lat", 64'(n), 64'd33);
    chk("mtlo_run_prod", 64'(bus_if.lo), 64'h8F);

    // Reset in the middle of RUN
    @(posedge clk); #1;
    start_op(OP_MULTU, 32'd123, 32'd456);
    repeat (16) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_busy", 64'(bus_if.busy), 64'd0);
    chk("mrst_done", 64'(bus_if.done), 64'd0);
    chk("mrst_hi", 64'(bus_if.hi), 64'd0);
    chk("mrst_lo", 64'(bus_if.lo), 64'd0);
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (bus_if.done) extra++; end
    chk("mrst_no_done", 64'(extra), 64'd0);
    run_mul("post_rst", OP_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mul_seq
